gem_cluster_lut_scheduler: RTL and testbench

GEM_CLUSTER_LUT_SCHEDULER -- requirements
Module: gem_cluster_lut_scheduler

---
 rtl/gem_cluster_lut_scheduler.sv | 166 ++++++++++++++++
 tb/tb_gem_cluster_lut_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gem_cluster_lut_scheduler.sv
// rtl/gem_cluster_lut_scheduler.sv - issues latched GEM clusters one per cycle to the pad/roll lookup stage
module gem_cluster_lut_scheduler #(
  parameter int MXCLST   = 8,
  parameter int CLSTBITS = 14,
  parameter int IDXBITS  = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       bx_strobe,
  input  logic [MXCLST-1:0]          cluster_vpf,
  input  logic [MXCLST*CLSTBITS-1:0] clusters,
  output logic [CLSTBITS-1:0]        lut_cluster,
  output logic                       lut_vpf,
  output logic [2:0]                 lut_roll,
  output logic [7:0]                 lut_pad,
  output logic [2:0]                 lut_size,
  output logic                       result_we,
  output logic [IDXBITS-1:0]         result_index,
  output logic                       busy,
  output logic                       done,
  output logic [IDXBITS:0]           issue_count,
  output logic                       overflow,
  output logic [7:0]                 overflow_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [MXCLST-1:0]          pending;
  logic [MXCLST*CLSTBITS-1:0] set_buf;
  logic [IDXBITS:0]           issue_cnt;
  logic [IDXBITS-1:0]         lut_index;

  logic                       accept;
  logic                       drop;
  logic                       issue;
  logic [MXCLST-1:0]          src_mask;
  logic [MXCLST*CLSTBITS-1:0] src_data;
  logic [CLSTBITS-1:0]        src_slot [MXCLST];
  logic [IDXBITS-1:0]         sel_idx;
  logic [MXCLST-1:0]          sel_onehot;
  logic [CLSTBITS-1:0]        sel_word;

  logic                       lut_vpf_nxt;
  logic                       busy_nxt;
  logic                       done_nxt;
  logic                       overflow_nxt;

  assign accept = bx_strobe && (state == IDLE || state == DONE);
  assign drop   = bx_strobe && (state == SCAN || state == DRAIN);

  // The first slot of a set is issued straight from the inputs at acceptance so it appears one cycle after the strobe.
  always_comb begin
    src_mask = accept ? cluster_vpf : pending;
    src_data = accept ? clusters    : set_buf;
    for (int k = 0; k < MXCLST; k++) begin
      src_slot[k] = src_data[k*CLSTBITS +: CLSTBITS];
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int k = MXCLST - 1; k >= 0; k--) begin
      if (src_mask[k]) begin
        sel_idx = IDXBITS'(k);
      end
    end
  end

  assign sel_onehot = MXCLST'(1) << sel_idx;
  assign sel_word   = src_slot[sel_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // In SCAN, pending holds the slots not yet issued; the slot on lut_* this cycle is already cleared.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bx_strobe) begin
          state_nxt = (cluster_vpf != '0) ? SCAN : DRAIN;
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN:    state_nxt = (pending != '0) ? SCAN : DRAIN;
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue        = (state_nxt == SCAN);
    lut_vpf_nxt  = issue;
    busy_nxt     = (state_nxt != IDLE);
    done_nxt     = (state_nxt == DONE);
    overflow_nxt = drop;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= '0;
      set_buf   <= '0;
      issue_cnt <= '0;
    end else begin
      if (accept) begin
        set_buf <= clusters;
      end
      if (accept || state == SCAN) begin
        pending <= src_mask & ~sel_onehot;
      end
      if (accept) begin
        issue_cnt <= issue ? (IDXBITS+1)'(1) : '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lut_cluster  <= '0;
      lut_index    <= '0;
      lut_vpf      <= 1'b0;
      result_we    <= 1'b0;
      result_index <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      lut_vpf <= lut_vpf_nxt;
      if (issue) begin
        lut_cluster <= sel_word;
        lut_index   <= sel_idx;
      end
      // Lookup stage has a fixed one-cycle latency, so results trail the issue by exactly one clock.
      result_we    <= lut_vpf;
      result_index <= lut_index;
      busy         <= busy_nxt;
      done         <= done_nxt;
      overflow     <= overflow_nxt;
      if (overflow_nxt && overflow_cnt != 8'hFF) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end

  assign issue_count = issue_cnt;
  assign lut_pad     = lut_cluster[7:0];
  assign lut_roll    = lut_cluster[10:8];
  assign lut_size    = lut_cluster[13:11];

endmodule

// File: tb/tb_gem_cluster_lut_scheduler.sv
// tb/tb_gem_cluster_lut_scheduler.sv - table, sequence and random checks of the GEM cluster LUT scheduler
module tb_gem_cluster_lut_scheduler;

  localparam int MXCLST   = 8;
  localparam int CLSTBITS = 14;
  localparam int IDXBITS  = 3;
  localparam int DW       = MXCLST * CLSTBITS;
  localparam int MAXC     = 8192;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 bx_strobe = 1'b0;
  logic [MXCLST-1:0]    cluster_vpf = '0;
  logic [DW-1:0]        clusters = '0;
  logic [CLSTBITS-1:0]  lut_cluster;
  logic                 lut_vpf;
  logic [2:0]           lut_roll;
  logic [7:0]           lut_pad;
  logic [2:0]           lut_size;
  logic                 result_we;
  logic [IDXBITS-1:0]   result_index;
  logic                 busy;
  logic                 done;
  logic [IDXBITS:0]     issue_count;
  logic                 overflow;
  logic [7:0]           overflow_cnt;

  gem_cluster_lut_scheduler #(
    .MXCLST(MXCLST), .CLSTBITS(CLSTBITS), .IDXBITS(IDXBITS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bx_strobe(bx_strobe),
    .cluster_vpf(cluster_vpf), .clusters(clusters),
    .lut_cluster(lut_cluster), .lut_vpf(lut_vpf), .lut_roll(lut_roll),
    .lut_pad(lut_pad), .lut_size(lut_size), .result_we(result_we),
    .result_index(result_index), .busy(busy), .done(done),
    .issue_count(issue_count), .overflow(overflow), .overflow_cnt(overflow_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = -1;

  // Expected-event timeline, indexed by cycle number
  logic                m_vpf  [MAXC];
  logic [CLSTBITS-1:0] m_word [MAXC];
  logic                m_rwe  [MAXC];
  logic [IDXBITS-1:0]  m_ridx [MAXC];
  logic                m_done [MAXC];
  int                  m_cnt  [MAXC];
  logic                m_busy [MAXC];
  logic                m_ovf  [MAXC];
  int                  m_free;
  logic [CLSTBITS-1:0] m_last;
  int                  m_ocnt;

  typedef struct {
    logic [7:0] vpf;
    int         exp_cnt;
    int         exp_lat;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < MAXC; c++) begin
      m_vpf[c] = 1'b0; m_word[c] = '0; m_rwe[c] = 1'b0; m_ridx[c] = '0;
      m_done[c] = 1'b0; m_cnt[c] = 0; m_busy[c] = 1'b0; m_ovf[c] = 1'b0;
    end
    m_free = 0;
    m_last = '0;
    m_ocnt = 0;
  endtask

  // Strobe at cycle t: accepted once the previous set has reached its done cycle, otherwise dropped.
  task automatic model_strobe(input int t, input logic [7:0] v, input logic [DW-1:0] d);
    int n;
    n = 0;
    if (t + MXCLST + 3 >= MAXC) return;
    if (t >= m_free) begin
      for (int k = 0; k < MXCLST; k++) begin
        if (v[k]) begin
          m_vpf[t+1+n]  = 1'b1;
          m_word[t+1+n] = d[k*CLSTBITS +: CLSTBITS];
          m_rwe[t+2+n]  = 1'b1;
          m_ridx[t+2+n] = IDXBITS'(k);
          n++;
        end
      end
      for (int c = t + 1; c <= t + n + 2; c++) m_busy[c] = 1'b1;
      m_done[t+n+2] = 1'b1;
      m_cnt[t+n+2]  = n;
      m_free        = t + n + 2;
    end else begin
      m_ovf[t+1] = 1'b1;
    end
  endtask

  task automatic compare_cycle(input int c);
    if (c >= MAXC) return;
    if (m_vpf[c]) m_last = m_word[c];
    if (m_ovf[c] && m_ocnt < 255) m_ocnt++;
    check("lut_vpf", int'(lut_vpf), int'(m_vpf[c]));
    check("lut_cluster", int'(lut_cluster), int'(m_last));
    check("lut_pad", int'(lut_pad), int'(m_last[7:0]));
    check("lut_roll", int'(lut_roll), int'(m_last[10:8]));
    check("lut_size", int'(lut_size), int'(m_last[13:11]));
    check("result_we", int'(result_we), int'(m_rwe[c]));
    if (m_rwe[c]) check("result_index", int'(result_index), int'(m_ridx[c]));
    check("busy", int'(busy), int'(m_busy[c]));
    check("done", int'(done), int'(m_done[c]));
    if (m_done[c]) check("issue_count", int'(issue_count), m_cnt[c]);
    check("overflow", int'(overflow), int'(m_ovf[c]));
    check("overflow_cnt", int'(overflow_cnt), m_ocnt);
    if (done) done_cyc = c;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < MXCLST; k++) d[k*CLSTBITS +: CLSTBITS] = CLSTBITS'($urandom);
    return d;
  endfunction

  task automatic step(input logic s, input logic [7:0] v, input logic [DW-1:0] d);
    @(negedge clock);
    cyc++;
    compare_cycle(cyc);
    bx_strobe   = s;
    cluster_vpf = v;
    clusters    = d;
    if (s) model_strobe(cyc, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), rand_data());
  endtask

  task automatic run_set(input string nm, input logic [7:0] v, input int ecnt, input int elat);
    int t0;
    step(1'b1, v, rand_data());
    t0 = cyc;
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 8'($urandom), rand_data());
      if (done_cyc > t0) break;
    end
    check({nm, "_done_latency"}, done_cyc - t0, elat);
    check({nm, "_issue_count"}, int'(issue_count), ecnt);
  endtask

  initial begin
    tbl[0] = '{vpf: 8'b1010_0100, exp_cnt: 3, exp_lat: 5};
    tbl[1] = '{vpf: 8'hFF,        exp_cnt: 8, exp_lat: 10};
    tbl[2] = '{vpf: 8'h00,        exp_cnt: 0, exp_lat: 2};
    tbl[3] = '{vpf: 8'h01,        exp_cnt: 1, exp_lat: 3};
    tbl[4] = '{vpf: 8'h80,        exp_cnt: 1, exp_lat: 3};
    tbl[5] = '{vpf: 8'h55,        exp_cnt: 4, exp_lat: 6};
    tbl[6] = '{vpf: 8'hF0,        exp_cnt: 4, exp_lat: 6};

    model_clear();
    idle(2);
    reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 7; i++) begin
      run_set($sformatf("tbl%0d", i), tbl[i].vpf, tbl[i].exp_cnt, tbl[i].exp_lat);
      idle(1);
    end

    // Back-to-back: second strobe lands in the DONE cycle of the first set
    step(1'b1, 8'b1010_0100, rand_data());
    idle(4);
    step(1'b1, 8'h03, rand_data());
    step(1'b0, 8'h00, rand_data());
    check("b2b_issue_next_cycle", int'(lut_vpf), 1);
    idle(5);
    check("b2b_no_overflow", int'(overflow_cnt), 0);

    // Overflow: strobe while scanning is dropped
    step(1'b1, 8'hFF, rand_data());
    step(1'b0, 8'h00, rand_data());
    step(1'b1, 8'h0F, rand_data());
    step(1'b0, 8'h00, rand_data());
    check("ovf_pulse", int'(overflow), 1);
    check("ovf_cnt_one", int'(overflow_cnt), 1);
    idle(12);

    // Continuous strobing drops far more than 255 strobes
    for (int i = 0; i < 350; i++) step(1'b1, 8'($urandom), rand_data());
    idle(12);
    check("ovf_cnt_saturated", int'(overflow_cnt), 255);

    // Reset during the second issue of a 4-cluster set
    step(1'b1, 8'h0F, rand_data());
    idle(2);
    reset_n = 1'b0;
    #1;
    check("rst_lut_vpf", int'(lut_vpf), 0);
    check("rst_lut_cluster", int'(lut_cluster), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_issue_count", int'(issue_count), 0);
    check("rst_overflow_cnt", int'(overflow_cnt), 0);
    check("rst_result_we", int'(result_we), 0);
    model_clear();
    idle(2);
    reset_n = 1'b1;
    idle(3);
    run_set("post_reset", 8'h01, 1, 3);
    idle(2);

    // Randomized sets with occasional dropped strobes
    for (int i = 0; i < 600; i++) begin
      logic [7:0] v;
      int sel;
      sel = $urandom_range(0, 7);
      v   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      step($urandom_range(0, 5) == 0, v, rand_data());
    end
    idle(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
